tick_generator_multi: RTL

//  Parametrised multi-channel successor to the single fixed 10 ms divider.

---
 rtl/tick_generator_multi_pkg.sv | 16 +
 rtl/tick_generator_multi_if.sv | 31 +++
 rtl/tick_generator_multi_channel.sv | 66 ++++++
 rtl/tick_generator_multi.sv | 67 ++++++
 4 files changed

// File: rtl/tick_generator_multi_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_pkg;

  localparam int TICK_CNT_W    = 24;
  localparam int TICK_DIV_10MS = 5_000_000;
  localparam int TICK_DIV_1MS  = 500_000;
  localparam int TICK_MAX_CH   = 16;

  // Widest channel-select field, enough to address TICK_MAX_CH channels.
  typedef logic [$clog2(TICK_MAX_CH)-1:0] tick_ch_t;

  function automatic int tick_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tick_generator_multi_if.sv
// Control/status bundle between the bank controller and the tick generator.
interface tick_generator_multi_if
  import tick_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = TICK_CNT_W
) ();

  localparam int CH_W = tick_ch_w(NUM_CH);

  logic              enable;
  logic              sync_all;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] wave;

  modport master (
    output enable, sync_all, cfg_we, cfg_ch, cfg_div,
    input  cfg_ack, cfg_err, tick, wave
  );

  modport slave (
    input  enable, sync_all, cfg_we, cfg_ch, cfg_div,
    output cfg_ack, cfg_err, tick, wave
  );

endinterface

// File: rtl/tick_generator_multi_channel.sv
// One divided timebase: programmable divisor, counter, tick strobe and square wave.
module tick_channel #(
  parameter int          CNT_W       = 24,
  parameter int unsigned DIV_DEFAULT = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             wave_o
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;

  // Next-state: sync beats a write, a write beats the terminal count.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wave_d = wave_q;
    if (sync_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (wr_i) begin
      div_d = wr_div_i;
      cnt_d = '0;
    end else if (div_q == '0) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == div_q - CNT_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= CNT_W'(DIV_DEFAULT);
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wave_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wave_q <= wave_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;

endmodule

// File: rtl/tick_generator_multi.sv
// NUM_CH independent programmable tick/wave timebases with a shared divisor write port.
module tick_generator_multi
  import tick_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = TICK_CNT_W,
  parameter int unsigned DIV_DEFAULT = TICK_DIV_10MS
) (
  input  logic                   clk,
  input  logic                   reset,
  tick_generator_multi_if.slave  bus
);

  localparam int CH_W = tick_ch_w(NUM_CH);

  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] wave_s;
  logic              cfg_valid_s;
  logic              wr_ok_s;
  logic              ack_d, ack_q;
  logic              err_d, err_q;

  // Write decode; a sync on the same edge suppresses the write entirely.
  always_comb begin
    cfg_valid_s = ({1'b0, bus.cfg_ch} < (CH_W + 1)'(NUM_CH));
    wr_ok_s     = bus.cfg_we & ~bus.sync_all;
    ack_d       = wr_ok_s & cfg_valid_s;
    err_d       = wr_ok_s & ~cfg_valid_s;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_s[i] = ack_d & (bus.cfg_ch == CH_W'(i));
    end
  end

  // Write acknowledge / error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable_i (bus.enable),
      .sync_i   (bus.sync_all),
      .wr_i     (wr_s[g]),
      .wr_div_i (bus.cfg_div),
      .tick_o   (tick_s[g]),
      .wave_o   (wave_s[g])
    );
  end

  assign bus.tick    = tick_s;
  assign bus.wave    = wave_s;
  assign bus.cfg_ack = ack_q;
  assign bus.cfg_err = err_q;

endmodule
